// File: rtl/seq_divider_pkg.sv
// Shared arithmetic-sequencer definitions: FSM state encoding common to the
// sequential multiplier and divider, plus the iteration-counter width helper.
package seq_arith_defs;

    // Controller states (same encoding as the shift-add multiplier FSM)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Iteration counter width: enough to count 0 .. n-1
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_divider_ripple_adder.sv
// Ripple-carry adder built from a chain of Full_Adder cells. The divider uses
// it in subtract mode (inverted B, c_in = 1) for the trial subtraction.

// Single-bit full adder cell
module Full_Adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// N-bit ripple adder: carry propagates LSB to MSB through the cell array
module ripple_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);
    logic [N:0] carry;

    assign carry[0] = c_in;

    for (genvar g = 0; g < N; g++) begin : g_fa
        Full_Adder u_fa (
            .a    (a[g]),
            .b    (b[g]),
            .cin  (carry[g]),
            .s    (sum[g]),
            .cout (carry[g+1])
        );
    end

    assign c_out = carry[N];
endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// start/busy/done handshake matches the sequential multiplier: an accepted
// start is followed by N RUN cycles and a single DONE cycle, after which the
// block returns to IDLE. Results are registered and held until the next
// completion. A zero divisor takes the normal path; the algorithm then yields
// an all-ones quotient and remainder == dividend, and div_by_zero is flagged.
module seq_divider
    import seq_arith_defs::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);
    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  r_q;     // partial remainder
    logic [N-1:0]  q_q;     // dividend shifting out / quotient shifting in
    logic [N-1:0]  d_q;     // captured divisor
    logic          dbz_r;   // captured divisor == 0

    logic [N:0]    p;       // shifted partial remainder {R, next dividend bit}
    logic [N:0]    neg_d;   // one's complement of zero-extended divisor
    logic [N:0]    diff;
    logic          c;       // no borrow: P >= D
    logic [N-1:0]  r_nxt;
    logic [N-1:0]  q_nxt;
    logic          unused_diff_msb;

    assign p     = {r_q, q_q[N-1]};
    assign neg_d = ~{1'b0, d_q};

    // Trial subtraction P - D as P + ~D + 1
    ripple_adder #(.N(N + 1)) u_sub (
        .a     (p),
        .b     (neg_d),
        .c_in  (1'b1),
        .sum   (diff),
        .c_out (c)
    );

    // R < D holds after every step, so the new remainder always fits N bits
    assign unused_diff_msb = diff[N];
    assign r_nxt = c ? diff[N-1:0] : p[N-1:0];
    assign q_nxt = {q_q[N-2:0], c};

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    // Controller: IDLE -> RUN (N steps) -> DONE (one cycle) -> IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (cnt == LAST) begin
                        state <= ST_DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Working registers: capture operands on accepted start, then step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= '0;
            q_q   <= '0;
            d_q   <= '0;
            dbz_r <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                r_q   <= '0;
                q_q   <= dividend;
                d_q   <= divisor;
                dbz_r <= (divisor == '0);
            end
        end else if (state == ST_RUN) begin
            r_q <= r_nxt;
            q_q <= q_nxt;
        end
    end

    // Result registers: update only on the final step, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (state == ST_RUN && cnt == LAST) begin
            quotient    <= q_nxt;
            remainder   <= r_nxt;
            div_by_zero <= dbz_r;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized scoreboard bench for seq_divider. Expected results come from
// integer '/' and '%' (with the divide-by-zero convention); a monitor pops
// and compares on every done pulse.
module tb_seq_divider;
    localparam int N       = 8;
    localparam int CYC_MAX = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t   sb[$];
    longint done_cyc[$];
    longint cyc = 0;
    int     tests = 0;
    int     fails = 0;
    logic   prev_done = 1'b0;
    logic [N-1:0] hold_q = '0;
    logic [N-1:0] hold_r = '0;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = N'(int'(a) / int'(b));
            e.r   = N'(int'(a) % int'(b));
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every completed result against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            chk("done_width", {63'd0, prev_done}, 64'd0);
            done_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got q=%0d r=%0d expected no result", quotient, remainder);
            end else begin
                e = sb.pop_front();
                chk($sformatf("quotient %0d/%0d", e.a, e.b), quotient, e.q);
                chk($sformatf("remainder %0d/%0d", e.a, e.b), remainder, e.r);
                chk($sformatf("dbz %0d/%0d", e.a, e.b), div_by_zero, e.dbz);
                if (e.b != 0) begin
                    chk("identity", 64'(quotient) * 64'(e.b) + 64'(remainder), 64'(e.a));
                    chk("r_lt_d", {63'd0, remainder < e.b}, 64'd1);
                end
            end
        end
        prev_done = done;
    end

    // One operation with latency/busy/stability checks; optional start
    // re-pulse with different operands in RUN cycle 3
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit inject);
        exp_t e;
        int   lat;
        int   bc;
        bit   stable;
        e = model(a, b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        dividend = N'($urandom);
        divisor  = N'($urandom);
        lat = 1;
        bc = 0;
        stable = 1'b1;
        while (!done && lat < CYC_MAX) begin
            if (busy) bc++;
            if (quotient !== hold_q || remainder !== hold_r) stable = 1'b0;
            if (inject && lat == 3) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 8'd5;
            end
            if (inject && lat == 4) start = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(N + 1));
        chk("busy_cycles", 64'(bc), 64'(N));
        chk("stable_in_run", {63'd0, stable}, 64'd1);
        hold_q = e.q;
        hold_r = e.r;
        @(negedge clk);
        chk("idle_after_done", {62'd0, busy, done}, 64'd0);
    endtask

    // start held high: expect acceptance every N+2 cycles
    task automatic back_to_back(input int nops);
        exp_t e;
        int   base;
        base = done_cyc.size();
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < nops; i++) begin
            e = model(N'($urandom), N'($urandom_range(1, 255)));
            dividend = e.a;
            divisor  = e.b;
            sb.push_back(e);
            repeat (N + 2) @(negedge clk);
        end
        start = 1'b0;
        hold_q = e.q;
        hold_r = e.r;
        chk("b2b_done_count", 64'(done_cyc.size() - base), 64'(nops));
        for (int i = base + 1; i < done_cyc.size(); i++)
            chk("b2b_period", 64'(done_cyc[i] - done_cyc[i-1]), 64'(N + 2));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        chk("reset_outputs", {quotient, remainder, div_by_zero, busy, done}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_op(8'd100, 8'd7,   1'b0);
        run_op(8'd255, 8'd1,   1'b0);
        run_op(8'd255, 8'd255, 1'b0);
        run_op(8'd5,   8'd200, 1'b0);
        run_op(8'd0,   8'd9,   1'b0);
        run_op(8'd13,  8'd0,   1'b0);
        run_op(8'd20,  8'd3,   1'b0);
        // start re-pulsed during RUN must be ignored
        run_op(8'd100, 8'd7,   1'b1);
        run_op(8'd9,   8'd0,   1'b0);

        // Asynchronous reset between edges in the middle of RUN
        @(negedge clk);
        dividend = 8'd77;
        divisor  = 8'd4;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs", {quotient, remainder, div_by_zero, busy, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        hold_q = '0;
        hold_r = '0;
        run_op(8'd200, 8'd3, 1'b0);

        back_to_back(5);

        // Random sweep, about one in eight divisors zero
        for (int i = 0; i < 30; i++)
            run_op(N'($urandom), ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(1, 255)), 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
